tms_prog_loader: RTL

Wishbone slave inside the TMS1x00 user-project wrapper that lets the management-core firmware write and read back the CPU's program ROM image, then releases the TMS1x00 core from reset. It sits between the Caravel Wishbone bus and the program-memory macro. Firmware runs the "write program memory / verify program memory / run" sequence through this block. While the program runs, it hands the memory read port to the CPU's fetch address.

---
 rtl/tms_loader_pkg.sv | 21 ++
 rtl/tms_loader_csum.sv | 18 +
 rtl/tms_prog_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tms_loader_pkg.sv
// Shared definitions for the TMS1x00 program loader: register map, CTRL bits, FSM states.
package tms_loader_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_ADDR   = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_AUTOINC = 1;
   localparam int CTRL_CLRSUM  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD0,
      S_RD1,
      S_ACK
   } ld_state_t;

endpackage

// File: rtl/tms_loader_csum.sv
// 16-bit wrapping byte accumulator over loaded program bytes; clear wins over add.
module tms_loader_csum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        add,
   input  logic [7:0]  data,
   output logic [15:0] sum
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         sum <= '0;
      else if (add)
         sum <= sum + {8'h00, data};
   end

endmodule

// File: rtl/tms_prog_loader.sv
// Wishbone loader for the TMS1x00 program ROM; hands the memory port to the CPU while RUN=1.
// Optional load checksum in STATUS[31:16] when TMS_LOADER_CHECKSUM_EN is defined.
module tms_prog_loader
   import tms_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          ROM_AW    = 11
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [ROM_AW-1:0] cpu_pc_i,
   output logic              cpu_rst_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ROM_AW-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);

   ld_state_t         state;
   logic              run, autoinc, abort;
   logic              ld_en, ld_we;
   logic [ROM_AW-1:0] addr, addr_nxt;
   logic [7:0]        wdata;
   logic [15:0]       csum;
   logic              live, hit, req;
   logic [1:0]        off;
   logic [31:0]       reg_rd;

   assign live     = wbs_cyc_i & wbs_stb_i;
   assign hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign req      = live & hit;
   assign off      = wbs_adr_i[3:2];
   assign addr_nxt = autoinc ? addr + ROM_AW'(1) : addr;

   // DATA only lands here with RUN=1, where reads return 0
   always_comb begin
      reg_rd = '0;
      case (off)
         REG_CTRL: begin
            reg_rd[CTRL_RUN]     = run;
            reg_rd[CTRL_AUTOINC] = autoinc;
            reg_rd[CTRL_CLRSUM]  = 1'b0;
         end
         REG_ADDR:   reg_rd[ROM_AW-1:0] = addr;
         REG_STATUS: begin
            reg_rd[0]     = run;
            reg_rd[31:16] = csum;
         end
         default:    reg_rd = '0;
      endcase
   end

   // CPU owns the read port whenever RUN is set
   assign mem_en_o    = run ? 1'b1     : ld_en;
   assign mem_we_o    = run ? 1'b0     : ld_we;
   assign mem_addr_o  = run ? cpu_pc_i : addr;
   assign mem_wdata_o = wdata;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         cpu_rst_o <= 1'b1;
         run       <= 1'b0;
         autoinc   <= 1'b0;
         abort     <= 1'b0;
         addr      <= '0;
         ld_en     <= 1'b0;
         ld_we     <= 1'b0;
         wdata     <= '0;
      end else begin
         cpu_rst_o <= ~run;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         case (state)
            S_IDLE: begin
               abort <= 1'b0;
               if (req) begin
                  if (off == REG_DATA && !run) begin
                     ld_en <= 1'b1;
                     ld_we <= wbs_we_i;
                     if (wbs_we_i) begin
                        wdata <= wbs_dat_i[7:0];
                        state <= S_WR;
                     end else begin
                        state <= S_RD0;
                     end
                  end else begin
                     state     <= S_ACK;
                     wbs_ack_o <= 1'b1;
                     if (wbs_we_i) begin
                        case (off)
                           REG_CTRL: begin
                              run     <= wbs_dat_i[CTRL_RUN];
                              autoinc <= wbs_dat_i[CTRL_AUTOINC];
                           end
                           REG_ADDR: addr <= wbs_dat_i[ROM_AW-1:0];
                           default: ;
                        endcase
                     end else begin
                        wbs_dat_o <= reg_rd;
                     end
                  end
               end
            end
            S_WR: begin
               ld_en <= 1'b0;
               ld_we <= 1'b0;
               if (live) begin
                  state     <= S_ACK;
                  wbs_ack_o <= 1'b1;
                  addr      <= addr_nxt;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RD0: begin
               ld_en <= 1'b0;
               abort <= ~live;
               state <= S_RD1;
            end
            S_RD1: begin
               // a dropped strobe anywhere in the read kills the ack and the increment
               if (live && !abort) begin
                  state     <= S_ACK;
                  wbs_ack_o <= 1'b1;
                  wbs_dat_o <= {24'h0, mem_rdata_i};
                  addr      <= addr_nxt;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef TMS_LOADER_CHECKSUM_EN
   logic csum_add, csum_clr;
   assign csum_add = (state == S_WR) && live;
   assign csum_clr = (state == S_IDLE) && req && wbs_we_i && (off == REG_CTRL)
                     && wbs_dat_i[CTRL_CLRSUM];

   tms_loader_csum u_csum (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .clr  (csum_clr),
      .add  (csum_add),
      .data (wdata),
      .sum  (csum)
   );
`else
   assign csum = '0;
`endif

   logic unused;
   assign unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:ROM_AW]};

endmodule
